reset_sequencer: RTL and testbench

//  Downstream consumer of the reset generator's rst_out.

---
 rtl/rstseq_pkg.sv | 31 +++
 rtl/sync2.sv | 28 ++
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer.
//   - FSM state encoding (3-bit, kept as plain localparams so older
//     tooling and waveform viewers that decode by value keep working)
//   - default parameter values
//   - lowest_zero(): index of the lowest cleared bit in an 8-bit vector
package rstseq_pkg;

    localparam logic [2:0] ST_ASSERT   = 3'd0;
    localparam logic [2:0] ST_RELEASE  = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_GUARD    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    localparam int DEF_STAGES       = 4;
    localparam int DEF_GUARD_CYCLES = 16;
    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_CNT_W        = 8;

    // Returns the index of the lowest 0 bit; 0 if every bit is set.
    // Callers pad unused upper bits with 1s so they never win.
    function automatic logic [2:0] lowest_zero(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk  in   sampling clock
//   rst  in   async active-high reset, clears both stages to 0
//   d    in   W  asynchronous input
//   q    out  W  synchronised output, 2 clk latency
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds STAGES reset domains in reset after rst_in, then
// releases them one at a time (index 0 first). Each release waits for the
// previous domain's acknowledge plus a guard delay. Reports completion,
// acknowledge timeouts and loss of acknowledge after completion.
// Ports:
//   clk          in   system clock
//   rst_in       in   async active-high reset (from the reset generator)
//   soft_rst     in   sync; restarts the sequence from ASSERT
//   stage_ack    in   STAGES  per-domain ready, asynchronous level
//   rst_out      out  STAGES  per-domain reset, active-high
//   all_ready    out  all domains released and acknowledged
//   fault        out  sequence aborted (timeout or ack lost after DONE)
//   fault_stage  out  3  stage that timed out or dropped its ack
//   state_dbg    out  3  current FSM state (rstseq_pkg ST_* encoding)
// stage_ack is a level, not a valid/ready handshake: a domain raises it when
// it is ready and is expected to keep it high; only the synchronised value
// is ever looked at.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int STAGES       = DEF_STAGES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              soft_rst,
    input  logic [STAGES-1:0] stage_ack,
    output logic [STAGES-1:0] rst_out,
    output logic              all_ready,
    output logic              fault,
    output logic [2:0]        fault_stage,
    output logic [2:0]        state_dbg
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        idx;
    logic [STAGES-1:0] ack_s;
    logic [STAGES-1:0] idx_mask;
    logic [7:0]        ack_pad;
    logic              cur_ack;

    sync2 #(.W(STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst_in),
        .d   (stage_ack),
        .q   (ack_s)
    );

    // One-hot select of the stage being sequenced; avoids indexing with a
    // wider-than-needed idx.
    assign idx_mask = STAGES'(1) << idx;
    assign cur_ack  = |(ack_s & idx_mask);

    // Counter saturates rather than wrapping so a stuck state cannot
    // alias back to a terminal count.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Unused upper bits read as acked so they never become fault_stage.
    always_comb begin
        ack_pad = '1;
        ack_pad[STAGES-1:0] = ack_s;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            idx         <= '0;
            rst_out     <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else if (soft_rst) begin
            // Overrides any timeout or ack decision in the same cycle.
            state       <= ST_ASSERT;
            cnt         <= '0;
            idx         <= '0;
            rst_out     <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_out <= '1;
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RELEASE: begin
                    rst_out <= rst_out & ~idx_mask;
                    cnt     <= '0;
                    state   <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (cur_ack) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= ST_FAULT;
                        cnt         <= '0;
                        fault       <= 1'b1;
                        fault_stage <= idx;
                        rst_out     <= '1;
                        all_ready   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_GUARD: begin
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        cnt <= '0;
                        if (idx == 3'(STAGES - 1)) begin
                            state     <= ST_DONE;
                            all_ready <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_DONE: begin
                    if (!(&ack_s)) begin
                        state       <= ST_FAULT;
                        cnt         <= '0;
                        fault       <= 1'b1;
                        fault_stage <= lowest_zero(ack_pad);
                        rst_out     <= '1;
                        all_ready   <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    // Sticky until soft_rst or rst_in.
                    rst_out   <= '1;
                    all_ready <= 1'b0;
                    fault     <= 1'b1;
                end

                default: begin
                    state     <= ST_ASSERT;
                    cnt       <= '0;
                    idx       <= '0;
                    rst_out   <= '1;
                    all_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. The reference model works on absolute clock
// edge numbers: from the ack schedule it computes when each output change
// must happen and what the outputs become, and queues those events. A
// monitor pops one event for every observed output change.
module tb_reset_sequencer;

    localparam int S     = 4;
    localparam int G     = 16;
    localparam int T     = 255;
    localparam int NEVER = 1 << 30;
    localparam logic [8:0] RST_VAL = {4'hF, 1'b0, 1'b0, 3'd0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_in = 1'b1;
    logic          soft_rst = 1'b0;
    logic [S-1:0]  stage_ack = '0;
    logic [S-1:0]  rst_out;
    logic          all_ready;
    logic          fault;
    logic [2:0]    fault_stage;
    logic [2:0]    state_dbg;

    reset_sequencer #(
        .STAGES(S), .GUARD_CYCLES(G), .TIMEOUT(T), .CNT_W(8)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .soft_rst    (soft_rst),
        .stage_ack   (stage_ack),
        .rst_out     (rst_out),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage),
        .state_dbg   (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [28:0] exp_q[$];      // {edge[19:0], rst_out, all_ready, fault, fault_stage}
    logic [8:0]  last_exp;
    int          last_ev;

    // ---------------- scenario description ----------------
    int a_edge[S];              // first edge that samples stage_ack[i] high
    int rb;                     // edge count at rst_in release
    int drop_idx, drop_off, drop_len, drop_start;
    int soft_q[$];

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // First edge at which the FSM can act on ack i (2-flop delay; the
    // synchroniser only starts sampling after reset release).
    function automatic int ack_eff(input int i);
        return imax(a_edge[i], rb + 1) + 2;
    endfunction

    task automatic emit(input int e, input logic [8:0] v);
        if (v !== last_exp) begin
            exp_q.push_back({20'(e), v});
            last_exp = v;
        end
        if (e > last_ev) last_ev = e;
    endtask

    // One sequence run starting from a restart at edge b; events at or
    // after stop are cut off by a later soft reset.
    task automatic model_seg(input int b, input int stop, input bit last);
        int r, g, done;
        logic [3:0] m;
        r = b + G + 1;
        done = 0;
        for (int i = 0; i < S; i++) begin
            if (r >= stop) return;
            m = 4'hF << (i + 1);
            emit(r, {m, 1'b0, 1'b0, 3'd0});
            g = imax(r + 1, ack_eff(i));
            if (g > r + T) begin
                if (r + T < stop) emit(r + T, {4'hF, 1'b0, 1'b1, 3'(i)});
                return;
            end
            if (i < S - 1) r = g + G + 1;
            else           done = g + G;
        end
        if (done >= stop) return;
        emit(done, {4'h0, 1'b1, 1'b0, 3'd0});
        if (last && drop_idx >= 0) begin
            drop_start = done + drop_off;
            if (drop_start + 2 < stop)
                emit(drop_start + 2, {4'hF, 1'b0, 1'b1, 3'(drop_idx)});
        end
    endtask

    task automatic build_model();
        int base;
        base = rb;
        foreach (soft_q[k]) begin
            model_seg(base, soft_q[k], 1'b0);
            emit(soft_q[k], RST_VAL);
            base = soft_q[k];
        end
        model_seg(base, NEVER, 1'b1);
    endtask

    // ---------------- monitor ----------------
    logic [8:0]  prev_o;
    logic [8:0]  cur_o;
    logic [28:0] ev;
    always @(negedge clk) begin
        cur_o = {rst_out, all_ready, fault, fault_stage};
        if (rst_in) begin
            prev_o = cur_o;
        end else if (cur_o !== prev_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change edge=%0d got=%b expected no change", cyc, cur_o);
            end else begin
                ev = exp_q.pop_front();
                if (ev[28:9] !== 20'(cyc) || ev[8:0] !== cur_o) begin
                    errors++;
                    $display("FAIL output_event got edge=%0d value=%b expected edge=%0d value=%b",
                             cyc, cur_o, ev[28:9], ev[8:0]);
                end
            end
            prev_o = cur_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic setup();
        soft_q.delete();
        drop_idx   = -1;
        drop_off   = 1;
        drop_len   = 0;
        drop_start = NEVER;
    endtask

    // Asserts rst_in between clock edges and checks the asynchronous effect.
    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_in    = 1'b1;
        soft_rst  = 1'b0;
        stage_ack = '0;
        #1;
        chk("async_reset", 32'({rst_out, all_ready, fault, fault_stage}), 32'(RST_VAL));
        repeat (3) @(negedge clk);
        exp_q.delete();
        #1;
        rst_in   = 1'b0;
        rb       = cyc;
        last_exp = RST_VAL;
        last_ev  = cyc;
    endtask

    // Drives the ack schedule edge by edge; cut > 0 stops early (the
    // caller then resets mid-sequence and the rest of the queue is dropped).
    task automatic run(input int cut);
        int end_e, e;
        logic [S-1:0] v;
        build_model();
        end_e = (cut > 0) ? cut : last_ev + 40;
        while (cyc + 1 <= end_e) begin
            e = cyc + 1;
            for (int i = 0; i < S; i++) begin
                v[i] = (e >= a_edge[i]) &&
                       !(i == drop_idx && e >= drop_start && e < drop_start + drop_len);
            end
            stage_ack = v;
            soft_rst  = 1'b0;
            foreach (soft_q[k]) if (soft_q[k] == e) soft_rst = 1'b1;
            @(negedge clk);
            #1;
        end
        soft_rst = 1'b0;
        if (cut == 0) chk("leftover_events", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic acks_early();
        for (int i = 0; i < S; i++) a_edge[i] = rb + 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r1, r3, s1, s2;

        // T1: acks tied high, clean sequence to all_ready
        apply_reset(); setup(); acks_early();
        run(0);

        // T2: stage 2 never acks -> timeout fault on stage 2
        apply_reset(); setup(); acks_early(); a_edge[2] = NEVER;
        run(0);

        // T3: stage 1 ack drops for 5 cycles after DONE -> sticky fault
        apply_reset(); setup(); acks_early();
        drop_idx = 1; drop_off = 20; drop_len = 5;
        run(0);

        // T4: soft_rst in stage-3 WAIT_ACK, then again in FAULT, then full run
        apply_reset(); setup(); acks_early();
        r3 = rb + G + 1 + 3 * (G + 2);
        s1 = r3 + 10;
        s2 = s1 + G + 1 + 3 * (G + 2) + T + 5;
        a_edge[3] = s2;
        soft_q.push_back(s1);
        soft_q.push_back(s2);
        run(0);

        // T5: rst_in mid-GUARD of stage 0, and while in DONE
        apply_reset(); setup(); acks_early();
        run(rb + G + 1 + 5);
        apply_reset(); setup(); acks_early();
        run(rb + G + 1 + 3 * (G + 2) + 1 + G + 5);

        // T6: stage 1 ack lands exactly on the timeout edge (ack wins),
        // then one edge later (timeout wins)
        apply_reset(); setup(); acks_early();
        r1 = rb + 2 * G + 3;
        a_edge[1] = r1 + T - 2;
        run(0);
        apply_reset(); setup(); acks_early();
        r1 = rb + 2 * G + 3;
        a_edge[1] = r1 + T - 1;
        run(0);

        // Early ack at a higher index must not advance a lower stage
        apply_reset(); setup(); acks_early();
        a_edge[2] = rb + G + 1 + 2 * (G + 2) + 60;
        run(0);

        // Randomised schedules with occasional soft resets or ack drops
        for (int n = 0; n < 12; n++) begin
            apply_reset(); setup();
            for (int i = 0; i < S; i++) a_edge[i] = rb + int'($urandom_range(0, 380));
            if ($urandom_range(0, 3) == 0) begin
                soft_q.push_back(rb + int'($urandom_range(10, 400)));
            end else if ($urandom_range(0, 1) == 1) begin
                drop_idx = int'($urandom_range(0, S - 1));
                drop_off = int'($urandom_range(1, 30));
                drop_len = int'($urandom_range(1, 8));
            end
            run(0);
        end

        apply_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
